// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control-unit signal bundle between the FSM and the multi-cycle datapath
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic [1:0] MemDataSize;
  logic       MemDataSign;
  logic       SignExtend;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           MemDataSize, MemDataSign, SignExtend, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           MemDataSize, MemDataSign, SignExtend, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM sequencing the multi-cycle MIPS datapath
module multicycle_control #(
  parameter logic [5:0] BEQ_OP       = 6'd5,
  parameter bit         ILLEGAL_TRAP = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    S_START    = 4'd0,  S_FETCH    = 4'd1,  S_DECODE   = 4'd2,  S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,  S_MEMWB    = 4'd5,  S_MEMWRITE = 4'd6,  S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,  S_IMM_EX   = 4'd9,  S_IMM_WB   = 4'd10, S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12, S_JAL_WB   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RFORMAT = 6'd0,  OP_J   = 6'd2,  OP_JAL = 6'd3;
  localparam logic [5:0] OP_ADDI    = 6'd8,  OP_ANDI = 6'd12;
  localparam logic [5:0] OP_LB  = 6'd32, OP_LH  = 6'd33, OP_LW = 6'd35;
  localparam logic [5:0] OP_LBU = 6'd36, OP_LHU = 6'd37;
  localparam logic [5:0] OP_SB  = 6'd40, OP_SH  = 6'd41, OP_SW = 6'd43;

  state_t state_q, state_d;
  logic       is_load, is_store, ld_signed;
  logic [1:0] mem_size;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_START;
    else        state_q <= state_d;
  end

  assign bus.state = state_q;

  always_comb begin
    is_load   = bus.opcode inside {OP_LW, OP_LB, OP_LH, OP_LBU, OP_LHU};
    is_store  = bus.opcode inside {OP_SW, OP_SB, OP_SH};
    ld_signed = bus.opcode inside {OP_LW, OP_LH, OP_LB};
    if (bus.opcode inside {OP_LW, OP_SW})              mem_size = 2'd3;
    else if (bus.opcode inside {OP_LH, OP_LHU, OP_SH}) mem_size = 2'd2;
    else                                               mem_size = 2'd1;
  end

  always_comb begin
    state_d         = state_q;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 2'd0;
    bus.MemtoReg    = 2'd0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'd0;
    bus.ALUOp       = 3'd0;
    bus.PCSource    = 2'd0;
    bus.MemDataSize = 2'd0;
    bus.MemDataSign = 1'b0;
    bus.SignExtend  = 1'b0;
    bus.illegal_op  = 1'b0;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        bus.MemRead     = 1'b1;
        bus.MemDataSize = 2'd3;
        bus.ALUSrcB     = 2'd1;
        bus.IRWrite     = bus.mem_ready;
        bus.PCWrite     = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        bus.ALUSrcB = 2'd3;
        if (is_load || is_store)                      state_d = S_MEMADR;
        else if (bus.opcode == OP_RFORMAT)            state_d = S_RTYPE_EX;
        else if (bus.opcode inside {OP_ADDI, OP_ANDI}) state_d = S_IMM_EX;
        else if (bus.opcode == BEQ_OP)                state_d = S_BRANCH;
        else if (bus.opcode == OP_J)                  state_d = S_JUMP;
        else if (bus.opcode == OP_JAL)                state_d = S_JAL_WB;
        else begin
          state_d        = S_FETCH;
          bus.illegal_op = ILLEGAL_TRAP;
        end
      end
      S_MEMADR: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUSrcB    = 2'd2;
        bus.SignExtend = 1'b1;
        state_d        = is_load ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        bus.IorD        = 1'b1;
        bus.MemRead     = 1'b1;
        bus.MemDataSize = mem_size;
        bus.MemDataSign = ld_signed;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.RegWrite    = 1'b1;
        bus.MemtoReg    = 2'd1;
        bus.MemDataSize = mem_size;
        bus.MemDataSign = ld_signed;
        state_d         = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.IorD        = 1'b1;
        bus.MemWrite    = 1'b1;
        bus.MemDataSize = mem_size;
        bus.MemDataSign = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_RTYPE_EX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 3'd2;
        state_d     = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 2'd1;
        state_d      = S_FETCH;
      end
      S_IMM_EX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'd2;
        if (bus.opcode == OP_ANDI) bus.ALUOp = 3'd3;
        else                       bus.SignExtend = 1'b1;
        state_d = S_IMM_WB;
      end
      S_IMM_WB: begin
        bus.RegWrite   = 1'b1;
        bus.SignExtend = (bus.opcode != OP_ANDI);
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 3'd1;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'd1;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'd2;
        state_d      = S_FETCH;
      end
      S_JAL_WB: begin
        // $31 receives the PC already advanced in FETCH.
        bus.RegWrite = 1'b1;
        bus.RegDst   = 2'd2;
        bus.MemtoReg = 2'd2;
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'd2;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control with randomized instruction stream
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if bus();

  multicycle_control #(.BEQ_OP(6'd5), .ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mrd, mwr, irw, rw;
    logic [1:0] rd, m2r;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic [1:0] pcs, sz;
    logic       sgn, sx, ill;
  } ctl_t;

  localparam int K_R = 0, K_IMM = 1, K_LD = 2, K_ST = 3, K_BEQ = 4, K_J = 5, K_JAL = 6, K_ILL = 7;

  ctl_t exp_q[$];
  int   len_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int kind(input logic [5:0] op);
    case (op)
      6'd0:                              return K_R;
      6'd8, 6'd12:                       return K_IMM;
      6'd35, 6'd32, 6'd33, 6'd36, 6'd37: return K_LD;
      6'd43, 6'd40, 6'd41:               return K_ST;
      6'd5:                              return K_BEQ;
      6'd2:                              return K_J;
      6'd3:                              return K_JAL;
      default:                           return K_ILL;
    endcase
  endfunction

  function automatic logic [1:0] msize(input logic [5:0] op);
    if (op == 6'd35 || op == 6'd43) return 2'd3;
    if (op == 6'd33 || op == 6'd37 || op == 6'd41) return 2'd2;
    return 2'd1;
  endfunction

  // Expected control word for one cycle, straight from the per-state output table.
  function automatic ctl_t model(input int st, input logic [5:0] op, input logic rdy);
    ctl_t c;
    c = '0;
    c.st = 4'(st);
    case (st)
      1:  begin c.mrd = 1; c.sz = 3; c.asb = 1; c.irw = rdy; c.pcw = rdy; end
      2:  begin c.asb = 3; c.ill = (kind(op) == K_ILL); end
      3:  begin c.asa = 1; c.asb = 2; c.sx = 1; end
      4:  begin c.iord = 1; c.mrd = 1; c.sz = msize(op); c.sgn = (op == 35 || op == 33 || op == 32); end
      5:  begin c.rw = 1; c.m2r = 1; c.sz = msize(op); c.sgn = (op == 35 || op == 33 || op == 32); end
      6:  begin c.iord = 1; c.mwr = 1; c.sz = msize(op); c.sgn = 1; end
      7:  begin c.asa = 1; c.aop = 2; end
      8:  begin c.rw = 1; c.rd = 1; end
      9:  begin c.asa = 1; c.asb = 2; c.aop = (op == 12) ? 3'd3 : 3'd0; c.sx = (op != 12); end
      10: begin c.rw = 1; c.sx = (op != 12); end
      11: begin c.asa = 1; c.aop = 1; c.pcwc = 1; c.pcs = 1; end
      12: begin c.pcw = 1; c.pcs = 2; end
      13: begin c.rw = 1; c.rd = 2; c.m2r = 2; c.pcw = 1; c.pcs = 2; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic step(input int st, input logic rdy, input logic [5:0] op);
    @(posedge clk);
    #1;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    exp_q.push_back(model(st, op, rdy));
  endtask

  task automatic rst_step(input logic r);
    @(posedge clk);
    #1;
    rst_n         = r;
    bus.mem_ready = 1'($urandom_range(1, 0));
    exp_q.push_back(model(0, bus.opcode, bus.mem_ready));
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit abort);
    int k, base;
    k = kind(op);
    for (int i = 0; i < fw; i++) step(1, 1'b0, op);
    step(1, 1'b1, op);
    step(2, 1'($urandom_range(1, 0)), op);
    case (k)
      K_R:   begin step(7, 1'($urandom_range(1, 0)), op); step(8, 1'($urandom_range(1, 0)), op); end
      K_IMM: begin step(9, 1'($urandom_range(1, 0)), op); step(10, 1'($urandom_range(1, 0)), op); end
      K_LD: begin
        step(3, 1'($urandom_range(1, 0)), op);
        if (abort) begin
          step(4, 1'b0, op);
          rst_step(1'b0);
          rst_step(1'b0);
          rst_step(1'b1);
          return;
        end
        for (int i = 0; i < mw; i++) step(4, 1'b0, op);
        step(4, 1'b1, op);
        step(5, 1'($urandom_range(1, 0)), op);
      end
      K_ST: begin
        step(3, 1'($urandom_range(1, 0)), op);
        for (int i = 0; i < mw; i++) step(6, 1'b0, op);
        step(6, 1'b1, op);
      end
      K_BEQ: step(11, 1'($urandom_range(1, 0)), op);
      K_J:   step(12, 1'($urandom_range(1, 0)), op);
      K_JAL: step(13, 1'($urandom_range(1, 0)), op);
      default: ;
    endcase
    case (k)
      K_R, K_IMM, K_ST: base = 4;
      K_LD:             base = 5;
      K_ILL:            base = 2;
      default:          base = 3;
    endcase
    len_q.push_back(base + fw + (((k == K_LD) || (k == K_ST)) ? mw : 0));
  endtask

  ctl_t got, want;
  logic [3:0] prev_st = 4'd0;
  int         run_len = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      got = {bus.state, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
             bus.IRWrite, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB,
             bus.ALUOp, bus.PCSource, bus.MemDataSize, bus.MemDataSign, bus.SignExtend,
             bus.illegal_op};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL ctl t=%0t got st=%0d word=%h required st=%0d word=%h",
                 $time, got.st, got, want.st, want);
      end
      checks++;
      if (bus.MemRead && bus.MemWrite) begin
        errors++;
        $display("FAIL rd_wr_excl t=%0t got MemRead=1 MemWrite=1 required not both", $time);
      end
      if (bus.state == 4'd1 && prev_st != 4'd1) begin
        if (prev_st != 4'd0) begin
          checks++;
          if (len_q.size() == 0) begin
            errors++;
            $display("FAIL instr_len t=%0t got len=%0d required none pending", $time, run_len);
          end else if (len_q[0] != run_len) begin
            errors++;
            $display("FAIL instr_len t=%0t got %0d required %0d", $time, run_len, len_q[0]);
            void'(len_q.pop_front());
          end else begin
            void'(len_q.pop_front());
          end
        end
        run_len = 1;
      end else begin
        run_len++;
      end
      prev_st = bus.state;
    end
  end

  logic [5:0] legal_ops [14] = '{6'd0, 6'd8, 6'd12, 6'd2, 6'd3, 6'd5, 6'd35, 6'd32,
                                 6'd33, 6'd36, 6'd37, 6'd43, 6'd40, 6'd41};

  initial begin
    logic [5:0] op;
    bus.opcode    = 6'd0;
    bus.mem_ready = 1'b1;
    rst_n         = 1'b0;
    rst_step(1'b0);
    rst_step(1'b0);
    rst_step(1'b1);
    run_instr(6'd0,  0, 0, 1'b0);
    run_instr(6'd35, 2, 2, 1'b0);
    run_instr(6'd37, 0, 0, 1'b0);
    run_instr(6'd40, 0, 0, 1'b0);
    run_instr(6'd12, 0, 0, 1'b0);
    run_instr(6'd8,  0, 0, 1'b0);
    run_instr(6'd5,  0, 0, 1'b0);
    run_instr(6'd3,  0, 0, 1'b0);
    run_instr(6'd2,  1, 0, 1'b0);
    run_instr(6'd63, 0, 0, 1'b0);
    run_instr(6'd43, 1, 3, 1'b0);
    run_instr(6'd35, 0, 0, 1'b1);
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(9, 0) == 0) op = 6'($urandom_range(63, 0));
      else                           op = legal_ops[$urandom_range(13, 0)];
      run_instr(op, $urandom_range(3, 0), $urandom_range(3, 0),
                ($urandom_range(15, 0) == 0));
    end
    step(1, 1'b0, 6'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || len_q.size() != 0) begin
      errors++;
      $display("FAIL drain got exp=%0d len=%0d pending required 0", exp_q.size(), len_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences the multi-cycle MIPS datapath through fetch, decode, execute, memory and writeback phases.
- Replaces the single-cycle combinational decoder.
- Drives the PC, IR, register-file, ALU-mux and memory-interface control lines from a state register plus the IR opcode.
- Stalls on a memory ready handshake.

Parameters:
- BEQ_OP, 6'd5, opcode decoded as branch-if-equal.
- ILLEGAL_TRAP, 1, when 1, an unknown opcode pulses illegal_op and returns to FETCH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  IR[31:26]; valid from DECODE onward.
- mem_ready  input  1  memory has completed the current read/write this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if ALU zero.
- IorD  output  1  0 = PC addresses memory, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  load IR from memory data.
- RegWrite  output  1  register-file write.
- RegDst  output  2  0 = rt, 1 = rd, 2 = $31.
- MemtoReg  output  2  0 = ALUOut, 1 = MDR, 2 = PC.
- ALUSrcA  output  1  0 = PC, 1 = rs.
- ALUSrcB  output  2  0 = rt, 1 = const 4, 2 = imm, 3 = imm<<2.
- ALUOp  output  3  0 = add, 1 = sub, 2 = funct, 3 = and.
- PCSource  output  2  0 = ALU result, 1 = ALUOut, 2 = jump target.
- MemDataSize  output  2  1 = byte, 2 = half, 3 = word.
- MemDataSign  output  1  sign-extend loaded data.
- SignExtend  output  1  immediate sign-extend; 0 for ANDI.
- illegal_op  output  1  one-cycle pulse on undecodable opcode.
- state  output  4  current state, for debug.

Behaviour:
- Opcodes:
  - RFORMAT 0, ADDI 8, ANDI 12, J 2, JAL 3, BEQ BEQ_OP.
  - Loads: LW 35, LB 32, LH 33, LBU 36, LHU 37.
  - Stores: SW 43, SB 40, SH 41.
- Reset:
  - Async, sets state = START (0).
  - All outputs 0 while in START; START -> FETCH unconditionally.
- Outputs are decoded from state and opcode only; no output depends on mem_ready except as noted under FETCH, MEMREAD and MEMWRITE.
- Any control output not listed for a state is 0.
- States and transitions:
  - FETCH(1): IorD=0, MemRead=1, MemDataSize=3, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0.
    - IRWrite and PCWrite are asserted only when mem_ready=1.
    - Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
  - DECODE(2): ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target precompute). Next state by opcode:
    - load/store -> MEMADR
    - RFORMAT -> RTYPE_EX
    - ADDI/ANDI -> IMM_EX
    - BEQ -> BRANCH
    - J -> JUMP
    - JAL -> JAL_WB
    - other -> FETCH, with illegal_op=1 this cycle if ILLEGAL_TRAP.
  - MEMADR(3): ALUSrcA=1, ALUSrcB=2, ALUOp=0, SignExtend=1. Loads -> MEMREAD; stores -> MEMWRITE.
  - MEMREAD(4): IorD=1, MemRead=1, MemDataSize/MemDataSign from opcode. Stay until mem_ready, then -> MEMWB.
    - Size: word 3, half 2, byte 1.
    - Sign=1 for LW/LH/LB, 0 for LHU/LBU.
  - MEMWB(5): RegWrite=1, RegDst=0, MemtoReg=1; MemDataSize/MemDataSign held from MEMREAD. -> FETCH.
  - MEMWRITE(6): IorD=1, MemWrite=1, MemDataSize from opcode, MemDataSign=1. Stay until mem_ready, then -> FETCH.
  - RTYPE_EX(7): ALUSrcA=1, ALUSrcB=0, ALUOp=2. -> RTYPE_WB.
  - RTYPE_WB(8): RegWrite=1, RegDst=1, MemtoReg=0. -> FETCH.
  - IMM_EX(9): ALUSrcA=1, ALUSrcB=2. ALUOp=0 and SignExtend=1 for ADDI; ALUOp=3 and SignExtend=0 for ANDI. -> IMM_WB.
  - IMM_WB(10): RegWrite=1, RegDst=0, MemtoReg=0; SignExtend held from IMM_EX. -> FETCH.
  - BRANCH(11): ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1. -> FETCH.
  - JUMP(12): PCWrite=1, PCSource=2. -> FETCH.
  - JAL_WB(13): RegWrite=1, RegDst=2, MemtoReg=2, PCWrite=1, PCSource=2. -> FETCH.
    - The PC value written to $31 is the already-incremented PC, because the register write samples PC before the edge.
- State encodings 14 and 15 are unreachable; if entered, next state is FETCH and all outputs are 0.
- Cycle counts with mem_ready always 1:
  - R/I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - BEQ/J/JAL: 3 cycles.
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- MemRead and MemWrite are never both 1.
- Reset asserted mid-operation (e.g. in MEMREAD): outputs drop to 0 immediately; no RegWrite or PCWrite is issued for the aborted instruction.

Test Plan:
- Reset, then release with mem_ready=1 and opcode=0 -> state sequence START, FETCH, DECODE, RTYPE_EX, RTYPE_WB, FETCH; RegWrite=1 only in RTYPE_WB, with RegDst=1.
- LW (35) with mem_ready low for 2 cycles in both FETCH and MEMREAD -> 9 cycles FETCH-to-FETCH; IRWrite/PCWrite pulse once; MEMREAD shows MemDataSize=3, MemDataSign=1; MEMWB has RegWrite=1, MemtoReg=1.
- LHU (37), then SB (40) -> MEMREAD shows MemDataSize=2, MemDataSign=0; MEMWRITE shows MemDataSize=1, MemWrite=1, MemRead=0.
- ANDI (12) -> IMM_EX shows ALUOp=3, SignExtend=0; ADDI (8) -> ALUOp=0, SignExtend=1; both reach IMM_WB with RegDst=0.
- BEQ (5) -> BRANCH shows PCWriteCond=1, ALUOp=1, PCSource=1; JAL (3) -> JAL_WB shows RegDst=2, MemtoReg=2, PCWrite=1, PCSource=2.
- Opcode 6'd63 -> illegal_op pulses for 1 cycle in DECODE, then FETCH. Reset asserted in MEMREAD -> state=START the same cycle, all outputs 0.
